seq_divider: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider: integer quotient plus FRAC_W fractional bits.
- Successor to the vendor divider core; adds valid/ready handshakes on both sides, a divide-by-zero flag and an optional signed mode.
- Sits between the measurement/ratio datapaths and the downstream scaling logic, clocked on sys_clk.

---
 rtl/seq_div_pkg.sv | 18 +
 rtl/seq_div_step.sv | 23 ++
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_divider restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DIVIDEND_W = 25;
  localparam int DEF_DIVISOR_W  = 16;
  localparam int DEF_FRAC_W     = 16;

  function automatic int calc_iter(input int dividend_w, input int frac_w);
    return dividend_w + frac_w;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift a bit into the remainder, compare, subtract.
module seq_div_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] trial;
  logic [DIVISOR_W+1:0] ext_div;

  always_comb begin
    trial   = {rem_in, bit_in};
    ext_div = {2'b00, divisor};
    q_bit   = (trial >= ext_div);
    // The restored remainder is always below the divisor, so the top bit is free to drop.
    rem_out = (DIVISOR_W+1)'(q_bit ? trial - ext_div : trial);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with fractional bits and valid/ready handshakes.
// Define SEQ_DIV_SIGNED_EN to honour signed_mode (two's-complement operands and result).
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int FRAC_W     = DEF_FRAC_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [FRAC_W-1:0]     fractional,
  output logic                  div_by_zero
);

  localparam int ITER  = calc_iter(DIVIDEND_W, FRAC_W);
  localparam int CNT_W = $clog2(ITER + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_W:0]    rem_q, rem_d, rem_nxt;
  logic [ITER-1:0]       sh_q, sh_d;
  logic [ITER-1:0]       res_q, res_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  dbz_q, dbz_d;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic                  q_bit;

  seq_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (sh_q[ITER-1]),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_d;

  always_comb begin
    dvd_mag = (signed_mode && dividend[DIVIDEND_W-1]) ? -dividend : dividend;
    dvs_mag = (signed_mode && divisor[DIVISOR_W-1])   ? -divisor  : divisor;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) neg_q <= 1'b0;
    else         neg_q <= neg_d;
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    res_d   = res_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = dvs_mag;
          cnt_d = '0;
          rem_d = '0;
          sh_d  = ITER'(dvd_mag) << FRAC_W;
`ifdef SEQ_DIV_SIGNED_EN
          neg_d = signed_mode & (dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1]);
`endif
          if (divisor == '0) begin
            res_d   = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            res_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // The extra cycle after the last iteration applies the sign correction.
        if (cnt_q == CNT_W'(ITER)) begin
`ifdef SEQ_DIV_SIGNED_EN
          res_d = neg_q ? -res_q : res_q;
`endif
          state_d = DONE;
        end else begin
          rem_d = rem_nxt;
          sh_d  = sh_q << 1;
          res_d = {res_q[ITER-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = res_q[ITER-1:FRAC_W];
  assign div_by_zero = dbz_q;

  if (FRAC_W > 0) begin : g_frac
    assign fractional = res_q[FRAC_W-1:0];
  end else begin : g_nofrac
    assign fractional = '0;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider at default widths.
module tb_seq_divider;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] dividend;
  logic [15:0] divisor;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] quotient;
  logic [15:0] fractional;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [24:0] q;
    logic [15:0] f;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .fractional  (fractional),
    .div_by_zero (div_by_zero)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold > 0 keeps out_ready low that many cycles after out_valid.
  task automatic run_op(input logic [24:0] a, input logic [15:0] b, input logic sm,
                        input logic [24:0] eq, input logic [15:0] ef, input logic ed,
                        input int elat, input int hold);
    exp_t        e;
    exp_t        got;
    int          lat;
    logic [41:0] snap;
    @(negedge sys_clk);
    check("ready before accept", 64'(in_ready), 64'd1);
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    in_valid    = 1'b1;
    out_ready   = (hold == 0);
    @(posedge sys_clk); #1;
    e.q = eq; e.f = ef; e.dbz = ed;
    sb.push_back(e);
    in_valid    = 1'b0;
    dividend    = 25'($urandom);
    divisor     = 16'($urandom);
    signed_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    snap = {quotient, fractional, div_by_zero};
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = 25'($urandom);
      divisor  = 16'($urandom);
      @(posedge sys_clk); #1;
      check("hold stable", 64'({out_valid, in_ready, quotient, fractional, div_by_zero}),
            64'({2'b10, snap}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check("quotient", 64'(quotient), 64'(got.q));
      check("fractional", 64'(fractional), 64'(got.f));
      check("div_by_zero", 64'(div_by_zero), 64'(got.dbz));
    end
    @(posedge sys_clk); #1;
    check("idle after handshake", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  task automatic run_model(input logic [24:0] a, input logic [15:0] b);
    logic [63:0] full;
    full = (64'(a) << 16) / 64'(b);
    run_op(a, b, 1'b0, full[40:16], full[15:0], 1'b0, 42, 0);
  endtask

  initial begin
    int seen;
    sys_rst     = 1'b1;
    in_valid    = 1'b0;
    dividend    = '0;
    divisor     = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset state", 64'({in_ready, out_valid, quotient, fractional, div_by_zero}),
          64'({2'b10, 42'b0}));
    @(negedge sys_clk);
    sys_rst = 1'b0;

    run_op(25'd120, 16'd10, 1'b0, 25'd12, 16'h0000, 1'b0, 42, 0);
    run_op(25'd1,   16'd3,  1'b0, 25'd0,  16'h5555, 1'b0, 42, 0);
    run_op(25'd7,   16'd2,  1'b0, 25'd3,  16'h8000, 1'b0, 42, 0);
    // Divide-by-zero skips CALC: the result shows in the cycle right after acceptance.
    run_op(25'd55,  16'd0,  1'b0, 25'h1FFFFFF, 16'hFFFF, 1'b1, 0, 0);
    run_op(25'd55,  16'd0,  1'b1, 25'h1FFFFFF, 16'hFFFF, 1'b1, 0, 0);
    run_op(25'h1FFFFFF, 16'd1, 1'b0, 25'h1FFFFFF, 16'h0000, 1'b0, 42, 0);
    run_op(25'd1, 16'hFFFF, 1'b0, 25'd0, 16'h0001, 1'b0, 42, 0);
    run_op(25'd120, 16'd10, 1'b0, 25'd12, 16'h0000, 1'b0, 42, 10);

`ifdef SEQ_DIV_SIGNED_EN
    run_op(-25'sd7,   16'd2,  1'b1, 25'h1FFFFFC, 16'h8000, 1'b0, 42, 0);
    run_op(-25'sd120, 16'd10, 1'b1, 25'h1FFFFF4, 16'h0000, 1'b0, 42, 0);
    run_op(25'h1000000, 16'hFFFF, 1'b1, 25'h1000000, 16'h0000, 1'b0, 42, 0);
`else
    run_op(-25'sd7,   16'd2,  1'b1, 25'h0FFFFFC, 16'h8000, 1'b0, 42, 0);
    run_op(-25'sd120, 16'd10, 1'b1, 25'h0333327, 16'h3333, 1'b0, 42, 0);
    run_op(25'h1000000, 16'hFFFF, 1'b1, 25'h0000100, 16'h0100, 1'b0, 42, 0);
`endif

    for (int k = 0; k < 3; k++) begin
      run_model(25'($urandom), 16'($urandom_range(65535, 1)));
    end

    // Abort an operation with reset partway through CALC.
    @(negedge sys_clk);
    dividend    = 25'd120;
    divisor     = 16'd10;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    check("busy before reset", 64'({in_ready, out_valid}), 64'(2'b00));
    sys_rst = 1'b1;
    #1;
    check("reset abort", 64'({in_ready, out_valid, quotient, fractional, div_by_zero}),
          64'({2'b10, 42'b0}));
    @(negedge sys_clk);
    sys_rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge sys_clk); #1;
      if (out_valid) seen = 1;
    end
    check("no result after abort", 64'(seen), 64'd0);
    check("ready after abort", 64'(in_ready), 64'd1);
    run_op(25'd120, 16'd10, 1'b0, 25'd12, 16'h0000, 1'b0, 42, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
